// File: rtl/tile_mult_8x8.sv
// 8x8 signed tile multiplier: streams eight A rows, then eight B rows, from a
// row-wide memory port and accumulates A[:,k] x B[k,:] outer products into 64 wrapping sums.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tile_mult_8x8 #(
   parameter int DATA_W = `DATA_WIDTH,
   parameter int ADDR_W = `ADDR_WIDTH,
   parameter int DIM_W  = `DIM_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          mult_start,
   input  logic [ADDR_W-1:0]             base_A,
   input  logic [ADDR_W-1:0]             base_B,
   input  logic [DIM_W-1:0]              dim_col_A,
   input  logic [DIM_W-1:0]              dim_col_B,
   output logic                          mult_done,
   output logic [7:0][7:0][DATA_W-1:0]   mult_out,
   output logic                          busy,
   output logic                          rd_en,
   output logic [ADDR_W-1:0]             rd_addr,
   input  logic [7:0][DATA_W-1:0]        rd_data
);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, DRAIN, DONE} state_t;

   state_t                       state, state_nxt;
   logic                         accept;
   logic [2:0]                   row_cnt;
   logic [ADDR_W-1:0]            addr_p0;
   logic [ADDR_W-1:0]            base_b_q;
   logic [ADDR_W-1:0]            stride_a_q;
   logic [ADDR_W-1:0]            stride_b_q;
   logic                         vld_a_p1;
   logic                         vld_b_p1;
   logic [2:0]                   row_p1;
   logic [7:0][7:0][DATA_W-1:0]  a_tile;
   logic [7:0][7:0][DATA_W-1:0]  acc;

   // Product and sum both keep only the low DATA_W bits (two's-complement wrap).
   function automatic logic signed [DATA_W-1:0] mac_wrap(
      input logic signed [DATA_W-1:0] acc_in,
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [2*DATA_W-1:0] prod;
      prod = a * b;
      return acc_in + $signed(prod[DATA_W-1:0]);
   endfunction

   assign accept = mult_start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = 1'b0;
      mult_done = 1'b0;
      case (state)
         IDLE:    if (accept) state_nxt = LOAD_A;
         LOAD_A: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (row_cnt == 3'd7) state_nxt = LOAD_B;
         end
         LOAD_B: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (row_cnt == 3'd7) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            mult_done = 1'b1;
            state_nxt = accept ? LOAD_A : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // p0: request stage -- row counter and running stride adder for rd_addr
   always_ff @(posedge clock) begin
      if (reset)
         row_cnt <= 3'd0;
      else if (accept)
         row_cnt <= 3'd0;
      else if ((state == LOAD_A) || (state == LOAD_B))
         row_cnt <= row_cnt + 3'd1;
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         addr_p0    <= base_A;
         base_b_q   <= base_B;
         stride_a_q <= ADDR_W'(dim_col_A);
         stride_b_q <= ADDR_W'(dim_col_B);
      end else if (state == LOAD_A) begin
         addr_p0 <= (row_cnt == 3'd7) ? base_b_q : addr_p0 + stride_a_q;
      end else if (state == LOAD_B) begin
         addr_p0 <= addr_p0 + stride_b_q;
      end
   end

   assign rd_addr = addr_p0;

   // p1: memory returns the row requested in the previous cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_a_p1 <= 1'b0;
         vld_b_p1 <= 1'b0;
         row_p1   <= 3'd0;
      end else begin
         vld_a_p1 <= (state == LOAD_A);
         vld_b_p1 <= (state == LOAD_B);
         row_p1   <= row_cnt;
      end
   end

   // A rows land in the local tile; each B row k updates all 64 sums with column k of A.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_tile <= '0;
         acc    <= '0;
      end else begin
         if (accept)
            acc <= '0;
         else if (vld_b_p1)
            for (int i = 0; i < 8; i++)
               for (int j = 0; j < 8; j++)
                  acc[i][j] <= mac_wrap(acc[i][j], a_tile[i][row_p1], rd_data[j]);
         if (vld_a_p1)
            a_tile[row_p1] <= rd_data;
      end
   end

   assign mult_out = acc;

endmodule

// File: tb/tb_tile_mult_8x8.sv
// Bench for tile_mult_8x8: word-addressed memory model, per-cycle timing checks,
// and a matrix-product reference computed straight from the memory contents.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_tile_mult_8x8;
   localparam int DW  = `DATA_WIDTH;
   localparam int AW  = `ADDR_WIDTH;
   localparam int DMW = `DIM_WIDTH;

   typedef logic [AW-1:0]  addr_t;
   typedef logic [DW-1:0]  word_t;
   typedef logic [DMW-1:0] dim_t;
   typedef struct { addr_t ba; addr_t bb; dim_t da; dim_t db; } tile_t;
   typedef struct { tile_t t; int kind; bit has00; word_t exp00; bit has77; word_t exp77; } vec_t;

   logic                     clock = 1'b0;
   logic                     reset;
   logic                     mult_start;
   addr_t                    base_A, base_B;
   dim_t                     dim_col_A, dim_col_B;
   logic                     mult_done, busy, rd_en;
   addr_t                    rd_addr;
   logic [7:0][7:0][DW-1:0]  mult_out;
   logic [7:0][DW-1:0]       rd_data;

   word_t mem [2**AW];
   word_t ec  [8][8];
   int    checks = 0;
   int    errors = 0;

   tile_mult_8x8 dut (
      .clock(clock), .reset(reset), .mult_start(mult_start),
      .base_A(base_A), .base_B(base_B), .dim_col_A(dim_col_A), .dim_col_B(dim_col_B),
      .mult_done(mult_done), .mult_out(mult_out), .busy(busy),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (rd_en)
         for (int w = 0; w < 8; w++)
            rd_data[w] <= mem[rd_addr + addr_t'(w)];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic addr_t elem_addr(input addr_t base, input dim_t stride, input int row, input int col);
      return addr_t'(int'(base) + row * int'(stride) + col);
   endfunction

   function automatic vec_t mk(input int ba, input int bb, input int da, input int db, input int kind,
                               input bit h00, input int e00, input bit h77, input int e77);
      vec_t v;
      v.t.ba = addr_t'(ba); v.t.bb = addr_t'(bb); v.t.da = dim_t'(da); v.t.db = dim_t'(db);
      v.kind = kind; v.has00 = h00; v.exp00 = word_t'(e00); v.has77 = h77; v.exp77 = word_t'(e77);
      return v;
   endfunction

   function automatic tile_t rand_tile();
      tile_t p;
      p.ba = addr_t'($urandom); p.bb = addr_t'($urandom);
      p.da = dim_t'($urandom_range(0, 80)); p.db = dim_t'($urandom_range(0, 80));
      return p;
   endfunction

   task automatic check(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < 2**AW; i++) mem[i] = word_t'($urandom);
   endtask

   task automatic fill_kind(input vec_t v);
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++) begin
            case (v.kind)
               1: begin
                  mem[elem_addr(v.t.ba, v.t.da, a, b)] = (a == b) ? word_t'(1) : word_t'(0);
                  mem[elem_addr(v.t.bb, v.t.db, a, b)] = word_t'(a * 8 + b);
               end
               2: begin
                  mem[elem_addr(v.t.ba, v.t.da, a, b)] = word_t'(1);
                  mem[elem_addr(v.t.bb, v.t.db, a, b)] = word_t'(1);
               end
               3: begin
                  if (a == 0) mem[elem_addr(v.t.ba, v.t.da, 0, b)] = word_t'(32'h7FFF_FFFF);
                  if (b == 0) mem[elem_addr(v.t.bb, v.t.db, a, 0)] = word_t'(2);
               end
               default: ;
            endcase
         end
   endtask

   // C = A x B with A[i][k] and B[k][j] read from memory by row/column address.
   task automatic compute_model(input tile_t p);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            word_t s = '0;
            for (int k = 0; k < 8; k++)
               s = s + mem[elem_addr(p.ba, p.da, i, k)] * mem[elem_addr(p.bb, p.db, k, j)];
            ec[i][j] = s;
         end
   endtask

   task automatic compare_result(input string name);
      int    bad = 0;
      int    bi = 0, bj = 0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (mult_out[i][j] !== ec[i][j]) begin
               if (bad == 0) begin bi = i; bj = j; end
               bad++;
            end
      check(bad == 0, name, $sformatf("%0d elements differ, C[%0d][%0d]=%h required %h",
                                      bad, bi, bj, mult_out[bi][bj], ec[bi][bj]));
   endtask

   task automatic check_cycle(input int n, input tile_t p, input string tag);
      bit    exp_en   = (n >= 1) && (n <= 16);
      bit    exp_busy = (n >= 1) && (n <= 17);
      bit    exp_done = (n == 18);
      addr_t exp_addr = '0;
      bit    ok;
      if (n >= 1 && n <= 8)  exp_addr = elem_addr(p.ba, p.da, n - 1, 0);
      if (n >= 9 && n <= 16) exp_addr = elem_addr(p.bb, p.db, n - 9, 0);
      ok = (rd_en === exp_en) && (busy === exp_busy) && (mult_done === exp_done) &&
           (!exp_en || (rd_addr === exp_addr));
      check(ok, $sformatf("%s_cyc%0d", tag, n),
            $sformatf("rd_en=%b busy=%b done=%b rd_addr=%h, required rd_en=%b busy=%b done=%b rd_addr=%h",
                      rd_en, busy, mult_done, rd_addr, exp_en, exp_busy, exp_done, exp_addr));
   endtask

   task automatic drive(input tile_t p);
      base_A = p.ba; base_B = p.bb; dim_col_A = p.da; dim_col_B = p.db;
   endtask

   task automatic scramble();
      base_A = addr_t'($urandom); base_B = addr_t'($urandom);
      dim_col_A = dim_t'($urandom); dim_col_B = dim_t'($urandom);
   endtask

   // started: cycle 0 was the previous tile's DONE cycle. chain: start q in this tile's cycle 18.
   task automatic run_tile(input tile_t p, input bit started, input bit ghost, input bit chain,
                           input tile_t q, input string tag);
      compute_model(p);
      if (!started) begin
         @(negedge clock);
         drive(p);
         mult_start = 1'b1;
         check_cycle(0, p, tag);
      end
      for (int n = 1; n <= 18; n++) begin
         @(negedge clock);
         mult_start = 1'b0;
         scramble();
         if (ghost && n == 5) mult_start = 1'b1;
         check_cycle(n, p, tag);
         if (n == 18) begin
            compare_result({tag, "_result"});
            if (chain) begin
               drive(q);
               mult_start = 1'b1;
            end
         end
      end
      if (!chain) begin
         @(negedge clock);
         mult_start = 1'b0;
         check(!mult_done && !busy && !rd_en, {tag, "_idle"},
               $sformatf("done=%b busy=%b rd_en=%b, required all 0", mult_done, busy, rd_en));
         compare_result({tag, "_hold"});
      end
   endtask

   task automatic reset_abort(input int rc, input string tag);
      tile_t p = rand_tile();
      int    bad = 0;
      @(negedge clock);
      drive(p);
      mult_start = 1'b1;
      check_cycle(0, p, tag);
      for (int n = 1; n <= rc; n++) begin
         @(negedge clock);
         mult_start = 1'b0;
         check_cycle(n, p, tag);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check(!rd_en && !busy && !mult_done && (mult_out == '0), {tag, "_abort"},
            $sformatf("rd_en=%b busy=%b done=%b out_nonzero=%b, required all 0",
                      rd_en, busy, mult_done, mult_out != '0));
      for (int n = rc + 2; n <= 40; n++) begin
         @(negedge clock);
         if (mult_done || rd_en || busy) bad++;
      end
      check(bad == 0, {tag, "_quiet"}, $sformatf("%0d active cycles after reset, required 0", bad));
   endtask

   initial begin
      vec_t  tbl [6];
      tile_t p, q;
      int    bad;

      reset = 1'b1; mult_start = 1'b0;
      base_A = '0; base_B = '0; dim_col_A = '0; dim_col_B = '0;
      randomize_mem();
      repeat (3) @(negedge clock);
      check(!rd_en && !busy && !mult_done && (mult_out == '0), "reset_state",
            $sformatf("rd_en=%b busy=%b done=%b out_nonzero=%b, required all 0",
                      rd_en, busy, mult_done, mult_out != '0));
      reset = 1'b0;

      tbl[0] = mk('h0000, 'h0100,  8,  8, 1, 1'b1, 0, 1'b1, 63);
      tbl[1] = mk('h0200, 'h1000, 64, 32, 2, 1'b1, 8, 1'b1, 8);
      tbl[2] = mk('h3000, 'h4000,  8,  8, 3, 1'b1, 32'hFFFF_FFF0, 1'b0, 0);
      tbl[3] = mk('h5000, 'h6000,  0,  0, 0, 1'b0, 0, 1'b0, 0);
      tbl[4] = mk('hFFF0, 'hFFFC,  3, 'h101, 0, 1'b0, 0, 1'b0, 0);
      tbl[5] = mk('h8000, 'h9000,  0, 'h20, 2, 1'b1, 8, 1'b1, 8);

      for (int t = 0; t < 6; t++) begin
         randomize_mem();
         fill_kind(tbl[t]);
         run_tile(tbl[t].t, 1'b0, 1'b0, 1'b0, tbl[t].t, $sformatf("vec%0d", t));
         if (tbl[t].has00)
            check(mult_out[0][0] === tbl[t].exp00, $sformatf("vec%0d_c00", t),
                  $sformatf("C[0][0]=%h required %h", mult_out[0][0], tbl[t].exp00));
         if (tbl[t].has77)
            check(mult_out[7][7] === tbl[t].exp77, $sformatf("vec%0d_c77", t),
                  $sformatf("C[7][7]=%h required %h", mult_out[7][7], tbl[t].exp77));
      end

      for (int t = 0; t < 6; t++) begin
         randomize_mem();
         p = rand_tile();
         run_tile(p, 1'b0, 1'b0, 1'b0, p, $sformatf("rnd%0d", t));
      end

      randomize_mem();
      p = rand_tile();
      q = rand_tile();
      run_tile(p, 1'b0, 1'b1, 1'b1, q, "b2b_first");
      run_tile(q, 1'b1, 1'b0, 1'b0, q, "b2b_second");

      reset_abort(10, "rst10");
      reset_abort(13, "rst13");
      p = rand_tile();
      run_tile(p, 1'b0, 1'b0, 1'b0, p, "after_rst");

      @(negedge clock);
      drive(p);
      reset = 1'b1;
      mult_start = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      mult_start = 1'b0;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         if (mult_done || rd_en || busy) bad++;
         @(negedge clock);
      end
      check(bad == 0, "rst_start_same", $sformatf("%0d active cycles, required 0", bad));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile_mult_8x8.md
TILE_MULT_8X8 -- requirements
Module: tile_mult_8x8

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset; sampled on rising edge of clock.
REQ-003 mult_start  in  1  request to compute one 8x8 tile product; single-cycle pulse from the driver.
REQ-004 base_A, base_B  in  `ADDR_WIDTH each  word address of element [0][0] of the A tile and the B tile.
REQ-005 dim_col_A, dim_col_B  in  `DIM_WIDTH each  row stride in words (column count of the full A / B matrix).
REQ-006 mult_done  out  1  one-cycle pulse; mult_out valid.
REQ-007 mult_out  out  [7:0][7:0][`DATA_WIDTH-1:0]  tile result C[i][j], i = row, j = column.
REQ-008 busy  out  1  high while a tile is in progress.
REQ-009 rd_en  out  1  memory read request.
REQ-010 rd_addr  out  `ADDR_WIDTH  memory read word address.
REQ-011 rd_data  in  [7:0][`DATA_WIDTH-1:0]  8 consecutive words starting at rd_addr; valid exactly 1 cycle after rd_en.

Function
REQ-012 FSM states IDLE, LOAD_A, LOAD_B, DRAIN, DONE; reset state IDLE.
REQ-013 Start acceptance: mult_start sampled high in IDLE or DONE -> capture base_A, base_B, dim_col_A, dim_col_B, clear all 64 accumulators, go to LOAD_A; mult_start in any other state ignored.
REQ-014 Timing reference: cycle 0 = cycle mult_start is accepted.
REQ-015 LOAD_A, cycles 1-8: rd_en=1, rd_addr = base_A + r*dim_col_A for r=0..7 (issue in cycle r+1).
REQ-016 LOAD_B, cycles 9-16: rd_en=1, rd_addr = base_B + k*dim_col_B for k=0..7 (issue in cycle k+9).
REQ-017 Row offsets formed by a running stride adder (no multiplier); all address arithmetic modulo 2^`ADDR_WIDTH.
REQ-018 A row r data (cycles 2-9) stored into local A tile row r.
REQ-019 B row k data (cycles 10-17): acc[i][j] += A[i][k] * B[k][j] for all 64 (i,j) in that cycle.
REQ-020 DRAIN covers cycle 17 (last B data, rd_en=0); DONE is cycle 18.
REQ-021 Arithmetic: operands two's-complement signed `DATA_WIDTH; products and sums wrap modulo 2^`DATA_WIDTH.
REQ-022 Cycle 18: mult_done=1 for exactly one cycle; busy=0.
REQ-023 mult_out = acc; holds the last result until the next accepted start clears it.
REQ-024 busy=1 in cycles 1-17, 0 in IDLE and DONE.
REQ-025 DONE -> IDLE next cycle unless a new start is accepted (back-to-back: next tile's cycle 0 = that DONE cycle).
REQ-026 rd_en=0 outside LOAD_A/LOAD_B; rd_addr value outside those states is don't-care.
REQ-027 dim_col = 0 legal: all 8 reads of that operand hit the same address.
REQ-028 Input bases/dims may change after acceptance without affecting the tile in progress.

Reset
REQ-029 On reset: state IDLE, rd_en=0, mult_done=0, busy=0, mult_out all zero, accumulators and A tile zero.
REQ-030 Reset mid-operation aborts the tile; no mult_done for it; next start after reset behaves as from power-up.
REQ-031 Reset and mult_start high in the same cycle: reset wins, start dropped.

Verification
REQ-032 A = identity at base_A=0x000 stride 8, B rows 0..7 = {k*8+j} at base_B=0x100 stride 8, start in cycle 0 -> mult_done only in cycle 18, C[i][j] = i*8+j.
REQ-033 Same start -> rd_addr 0x000,0x008,..,0x038 in cycles 1-8, then 0x100,..,0x138 in cycles 9-16; rd_en=0 in cycles 0, 17, 18.
REQ-034 All A and B elements = 1, dim_col_A=64, dim_col_B=32 -> all C = 8; A row addresses step by 64, B row addresses step by 32.
REQ-035 Second mult_start in cycle 5 -> ignored: one mult_done in cycle 18; new start in cycle 18 -> next mult_done in cycle 36; mult_out holds the first result through cycle 18.
REQ-036 reset in cycle 10 -> from cycle 11 rd_en=0, busy=0, mult_out=0; no mult_done through cycle 40.
REQ-037 `DATA_WIDTH=32, A[0][k]=0x7FFFFFFF, B[k][0]=2 for all k -> C[0][0] = 0xFFFFFFF0 (wrapped).
